// File: rtl/seqgen_pkg.sv
// Shared types and constants for the sequence frame generator.
// Level defaults, FSM state encoding and CRC-8 constants.
package seqgen_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam int LEVEL_ONE_DEF  = 768;
  localparam int LEVEL_ZERO_DEF = 256;
  localparam int LEVEL_IDLE_DEF = 512;

  localparam int         CRC_W    = 8;
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

endpackage

// File: rtl/seqgen_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps.
// strobe marks the first clock of a bit, last marks its final clock.
module seqgen_bit_timer
  import seqgen_pkg::*;
#(
  parameter int CLKS_PER_BIT = 36
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic strobe,
  output logic last
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

  assign strobe = (count == '0);
  assign last   = (count == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/sequence_frame_generator.sv
// Serial frame generator: sends {ID, payload[, CRC-8]} MSB first as level codes.
// Define SEQGEN_CRC_EN to append a CRC-8 tail to every frame.
module sequence_frame_generator
  import seqgen_pkg::*;
#(
  parameter int                PAYLOAD_W    = 32,
  parameter int                ID_W         = 8,
  parameter logic [ID_W-1:0]   ID_VALUE     = 'hB4,
  parameter int                CLKS_PER_BIT = 36,
  parameter int                OUT_W        = 10,
  parameter logic [OUT_W-1:0]  LEVEL_ONE    = OUT_W'(LEVEL_ONE_DEF),
  parameter logic [OUT_W-1:0]  LEVEL_ZERO   = OUT_W'(LEVEL_ZERO_DEF),
  parameter logic [OUT_W-1:0]  LEVEL_IDLE   = OUT_W'(LEVEL_IDLE_DEF)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  // sequence/repeat are reserved words, hence the suffixed names
  input  logic [PAYLOAD_W-1:0] sequence_data,
  input  logic                 repeat_mode,
  input  logic                 stop,
  output logic                 ready,
  output logic [OUT_W-1:0]     sequence_out,
  output logic                 bit_strobe,
  output logic                 frame_done
);

`ifdef SEQGEN_CRC_EN
  localparam int TAIL_W = CRC_W;
`else
  localparam int TAIL_W = 0;
`endif
  localparam int HEAD_W  = ID_W + PAYLOAD_W;
  localparam int FRAME_W = HEAD_W + TAIL_W;
  localparam int BW      = $clog2(FRAME_W);

  function automatic logic [FRAME_W-1:0] build(
    input logic [PAYLOAD_W-1:0] p
  );
`ifdef SEQGEN_CRC_EN
    logic [HEAD_W-1:0] h;
    logic [7:0]        c;
    h = {ID_VALUE, p};
    c = CRC_INIT;
    for (int i = HEAD_W - 1; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ h[i]) ? CRC_POLY : 8'h00);
    end
    return {h, c};
`else
    return {ID_VALUE, p};
`endif
  endfunction

  state_t             state_q, state_nxt;
  logic [BW-1:0]      bit_q, bit_nxt;
  logic [FRAME_W-1:0] frame_q, frame_nxt;
  logic [FRAME_W-1:0] shifted;
  logic               rep_q, rep_nxt;
  logic               stop_q, stop_nxt;
  logic [OUT_W-1:0]   level_nxt;
  logic               tick_first;
  logic               tick_last;
  logic               last_bit;
  logic               sending;

  assign sending  = (state_q == S_SEND);
  assign last_bit = (bit_q == BW'(FRAME_W - 1));

  seqgen_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .restart(!sending),
    .strobe (tick_first),
    .last   (tick_last)
  );

  always_comb begin
    state_nxt = state_q;
    bit_nxt   = bit_q;
    frame_nxt = frame_q;
    rep_nxt   = rep_q;
    stop_nxt  = stop_q;
    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (load) begin
            state_nxt = S_SEND;
            bit_nxt   = '0;
            frame_nxt = build(sequence_data);
            rep_nxt   = repeat_mode;
            stop_nxt  = 1'b0;
          end
        end
        S_SEND: begin
          if (stop) stop_nxt = 1'b1;
          if (tick_last) begin
            if (!last_bit) begin
              bit_nxt = bit_q + BW'(1);
            end else begin
              // wrap to bit 0; leave SEND unless repeating without stop
              bit_nxt = '0;
              if (!rep_q || stop_q || stop) begin
                state_nxt = S_IDLE;
                rep_nxt   = 1'b0;
                stop_nxt  = 1'b0;
              end
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    shifted   = frame_nxt << bit_nxt;
    level_nxt = LEVEL_IDLE;
    if (state_nxt == S_SEND) begin
      level_nxt = shifted[FRAME_W-1] ? LEVEL_ONE : LEVEL_ZERO;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_q        <= '0;
      frame_q      <= '0;
      rep_q        <= 1'b0;
      stop_q       <= 1'b0;
      sequence_out <= LEVEL_IDLE;
    end else begin
      state_q      <= state_nxt;
      bit_q        <= bit_nxt;
      frame_q      <= frame_nxt;
      rep_q        <= rep_nxt;
      stop_q       <= stop_nxt;
      sequence_out <= level_nxt;
    end
  end

  assign ready      = !sending;
  assign bit_strobe = sending && tick_first && enable;
  assign frame_done = sending && tick_last && last_bit && enable;

endmodule

// File: tb/tb_sequence_frame_generator.sv
// Self-checking bench for sequence_frame_generator (default parameters).
// Table vectors, directed corner scenarios and a random run against a model.
module tb_sequence_frame_generator;

  localparam int C = 36;
`ifdef SEQGEN_CRC_EN
  localparam int FW = 48;
`else
  localparam int FW = 40;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [31:0] seq = '0;
  logic        rep = 1'b0;
  logic        stop = 1'b0;
  logic        ready;
  logic [9:0]  sout;
  logic        strobe;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequence_frame_generator dut (
    .clock        (clk),
    .reset        (reset),
    .enable       (enable),
    .load         (load),
    .sequence_data(seq),
    .repeat_mode  (rep),
    .stop         (stop),
    .ready        (ready),
    .sequence_out (sout),
    .bit_strobe   (strobe),
    .frame_done   (done)
  );

  // CRC-8 as polynomial long division of msg*x^8 by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [39:0] msg);
    logic [47:0] r;
    r = {msg, 8'h00};
    for (int i = 47; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [127:0] mk_frame(input logic [31:0] p);
    logic [127:0] f;
    logic [39:0]  m;
    f = '0;
    m = {8'hB4, p};
`ifdef SEQGEN_CRC_EN
    f[47:0] = {m, crc_ref(m)};
`else
    f[39:0] = m;
`endif
    return f;
  endfunction

  // reference model: elapsed enabled clocks since the frame started
  logic         m_busy = 1'b0;
  int           m_e = 0;
  logic [127:0] m_frame = '0;
  logic         m_rep = 1'b0;
  logic         m_stop = 1'b0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_busy = 1'b0;
    end else if (enable) begin
      if (!m_busy) begin
        if (load) begin
          m_busy  = 1'b1;
          m_e     = 0;
          m_frame = mk_frame(seq);
          m_rep   = rep;
          m_stop  = 1'b0;
        end
      end else begin
        if (stop) m_stop = 1'b1;
        if (m_e == FW * C - 1) begin
          if (m_rep && !m_stop) m_e = 0;
          else m_busy = 1'b0;
        end else begin
          m_e++;
        end
      end
    end
  endtask

  task automatic model_cmp();
    logic [9:0] lvl;
    logic       b;
    if (!m_busy) begin
      chk("m_ready", ready, 1);
      chk("m_level", sout, 10'd512);
      chk("m_strobe", strobe, 0);
      chk("m_done", done, 0);
    end else begin
      b   = m_frame[FW - 1 - m_e / C];
      lvl = b ? 10'd768 : 10'd256;
      chk("m_ready", ready, 0);
      chk("m_level", sout, lvl);
      chk("m_strobe", strobe, (m_e % C == 0) && enable);
      chk("m_done", done, (m_e == FW * C - 1) && enable);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic run_frame(input logic [31:0] p, input string tag);
    int           k;
    int           dn;
    int           dk;
    logic [127:0] bits;
    seq  = p;
    rep  = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    seq  = $urandom;
    rep  = 1'b1;
    k = 0; dn = 0; dk = -1; bits = '0;
    while (!ready && k < 4000) begin
      if (k % C == 17) bits = {bits[126:0], sout == 10'd768};
      if (done) begin dn++; dk = k; end
      tick();
      k++;
    end
    rep = 1'b0;
    chk({tag, "_len"}, k, FW * C);
    chk({tag, "_bits"}, bits, mk_frame(p));
    chk({tag, "_ndone"}, dn, 1);
    chk({tag, "_done_at"}, dk, FW * C - 1);
  endtask

  typedef struct {
    logic        rst, en, ld;
    logic [31:0] sq;
    logic        rp, sp;
    logic        rdy;
    logic [9:0]  lvl;
    logic        stb, dn;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int k, dn, ns, st, en_k;

    tbl[0] = '{1, 1, 0, 32'h0, 0, 0, 1, 10'd512, 0, 0};
    tbl[1] = '{0, 1, 0, 32'h0, 0, 0, 1, 10'd512, 0, 0};
    tbl[2] = '{0, 1, 0, 32'h0, 0, 1, 1, 10'd512, 0, 0};
    tbl[3] = '{0, 0, 1, 32'hAA, 0, 0, 1, 10'd512, 0, 0};
    tbl[4] = '{0, 1, 1, 32'hAA, 0, 0, 0, 10'd768, 1, 0};
    tbl[5] = '{0, 1, 1, 32'h55, 1, 0, 0, 10'd768, 0, 0};
    tbl[6] = '{1, 1, 1, 32'h55, 0, 0, 1, 10'd512, 0, 0};
    tbl[7] = '{1, 0, 0, 32'h0, 0, 0, 1, 10'd512, 0, 0};

    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; load = tbl[i].ld;
      seq = tbl[i].sq; rep = tbl[i].rp; stop = tbl[i].sp;
      tick();
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_level", i), sout, tbl[i].lvl);
      chk($sformatf("tbl%0d_strobe", i), strobe, tbl[i].stb);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
    end
    reset = 0; enable = 1; load = 0; stop = 0; rep = 0;
    tick();

    // basic frame with payload 0xAA, sampled mid-bit
    run_frame(32'h0000_00AA, "aa");
    run_frame(32'hDEAD_BEEF, "beef");

    // repeat mode, stop pulsed inside the second frame
    seq = 32'h1234_5678; rep = 1; load = 1;
    tick();
    load = 0; rep = 0;
    k = 0; dn = 0;
    while (!ready && k < 8000) begin
      if (done) dn++;
      stop = (k == FW * C + 100);
      tick();
      k++;
    end
    stop = 0;
    chk("rep_len", k, 2 * FW * C);
    chk("rep_ndone", dn, 2);
    chk("rep_idle_level", sout, 10'd512);

    // enable dropped for 50 clocks inside bit 5
    seq = $urandom; load = 1;
    tick();
    load = 0;
    k = 0; ns = 0; st = -1; en_k = -1;
    while (!ready && k < 4000) begin
      if (strobe) begin
        ns++;
        if (ns == 6) st = k;
        if (ns == 7) en_k = k;
      end
      enable = !(ns == 6 && st >= 0 && k >= st + 10 && k < st + 60);
      tick();
      k++;
    end
    enable = 1;
    chk("en_bit5_len", en_k - st, 86);
    chk("en_frame_len", k, FW * C + 50);

    // reset in the middle of bit 20, then a clean frame
    seq = $urandom; load = 1;
    tick();
    load = 0;
    k = 0; ns = 0;
    while (ns < 21 && k < 4000) begin
      if (strobe) ns++;
      tick();
      k++;
    end
    for (int i = 0; i < 5; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_ready", ready, 1);
    chk("rst_level", sout, 10'd512);
    chk("rst_done", done, 0);
    tick();
    run_frame($urandom, "after_rst");

    // load held high: refused on frame_done, taken once ready returns
    seq = 32'hF0F0_0F0F; load = 1;
    tick();
    k = 0;
    while (!done && k < 4000) begin
      tick();
      k++;
    end
    chk("hold_done_seen", done, 1);
    chk("hold_ready_at_done", ready, 0);
    tick();
    chk("hold_ready_after", ready, 1);
    tick();
    chk("hold_reaccept_ready", ready, 0);
    chk("hold_reaccept_strobe", strobe, 1);
    load = 0;
    reset = 1;
    tick();
    reset = 0;

    // random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      reset  = ($urandom % 4000) == 0;
      enable = ($urandom % 8) != 0;
      load   = ($urandom % 64) == 0;
      seq    = $urandom;
      rep    = ($urandom % 3) == 0;
      stop   = ($urandom % 700) == 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
